branch_ctrl: RTL and testbench

Sequencer for pipeline control flow around the execute-stage branch unit. It owns the architectural flags register (GT, E) that feeds the branch unit. It takes the branch unit's taken/target result and runs a redirect handshake with the fetch stage. While the redirect is outstanding it flushes the IF/ID and ID/EX latches and suppresses wrong-path flag updates.

---
 rtl/branch_ctrl.sv | 104 ++++++++++
 tb/tb_branch_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Redirect sequencer around the EX-stage branch unit: owns the GT/E flags and
// drives the fetch redirect handshake with IF/ID and ID/EX flushes.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             stall,
  input  logic             cmp_valid,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             fetch_ready,
  output logic [1:0]       flags,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_flag_ld;
  logic              w_done;
  logic [1:0]        r_flags;
  logic [PC_W-1:0]   r_pc;

  always_comb begin
    w_accept    = 1'b0;
    w_flag_ld   = 1'b0;
    w_done      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        w_accept  = ex_valid & ex_taken & ~stall;
        w_flag_ld = ex_valid & cmp_valid & ~stall;
        if (w_accept) w_state_nxt = REDIRECT;
      end
      REDIRECT: begin
        // EX contents are wrong-path here; only the fetch handshake matters
        w_done = fetch_ready;
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_flags <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_flag_ld) r_flags <= {cmp_eq, cmp_gt};
      if (w_accept)  r_pc    <= ex_target;
    end
  end

  // Handshake outputs decode straight from the state flop, so they stay registered
  assign flags          = r_flags;
  assign redirect_pc    = r_pc;
  assign redirect_valid = (r_state == REDIRECT);
  assign flush_if       = (r_state == REDIRECT);
  assign flush_id       = (r_state == REDIRECT);
  assign busy           = (r_state == REDIRECT);

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_accept && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + 1'b1;
      if ((r_state == REDIRECT) && !fetch_ready && (r_wait_cnt != '1))
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign taken_cnt = r_taken_cnt;
  assign wait_cnt  = r_wait_cnt;
`else
  assign taken_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; statistics expectations follow
// whether BRANCH_STATS_EN is defined for the build.
module tb_branch_ctrl;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, ex_taken, stall, cmp_valid, cmp_gt, cmp_eq, fetch_ready;
  logic [PC_W-1:0]  ex_target;
  logic [1:0]       flags;
  logic             redirect_valid, flush_if, flush_id, busy;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] taken_cnt, wait_cnt;

  int errors = 0;
  int checks = 0;

  branch_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_taken(ex_taken),
    .ex_target(ex_target), .stall(stall), .cmp_valid(cmp_valid),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .fetch_ready(fetch_ready),
    .flags(flags), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .busy(busy),
    .taken_cnt(taken_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic exp);
    chk({tag, ".rv"},   32'(redirect_valid), 32'(exp));
    chk({tag, ".fif"},  32'(flush_if),       32'(exp));
    chk({tag, ".fid"},  32'(flush_id),       32'(exp));
    chk({tag, ".busy"}, 32'(busy),           32'(exp));
  endtask

  task automatic chk_stats(input string tag, input int tk, input int wt);
`ifdef BRANCH_STATS_EN
    chk({tag, ".taken"}, 32'(taken_cnt), 32'(tk));
    chk({tag, ".wait"},  32'(wait_cnt),  32'(wt));
`else
    chk({tag, ".taken"}, 32'(taken_cnt), 32'(tk & 0));
    chk({tag, ".wait"},  32'(wait_cnt),  32'(wt & 0));
`endif
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_taken = 0; cmp_valid = 0; cmp_gt = 0; cmp_eq = 0; stall = 0;
  endtask

  initial begin
    rst = 1; idle_inputs(); fetch_ready = 0; ex_target = '0;
    #1;
    chk_ctl("reset", 1'b0);
    chk("reset.flags", 32'(flags), 0);
    chk("reset.pc", redirect_pc, 0);
    chk_stats("reset", 0, 0);
    step(); step();
    rst = 0;

    // Flags load, then same-cycle cmp + taken branch (basic redirect to 0x40)
    ex_valid = 1; cmp_valid = 1; cmp_gt = 1; cmp_eq = 0;
    step();
    chk("flags.gt", 32'(flags), 32'h1);
    chk_ctl("flags.idle", 1'b0);
    cmp_gt = 0; cmp_eq = 1; ex_taken = 1; ex_target = 32'h40; fetch_ready = 1;
    step();
    chk("flags.eq", 32'(flags), 32'h2);
    chk_ctl("basic.redir", 1'b1);
    chk("basic.pc", redirect_pc, 32'h40);
    idle_inputs();
    step();
    chk_ctl("basic.done", 1'b0);
    chk_stats("basic", 1, 0);

    // Fetch backpressure: 3 cycles not ready, then ready
    fetch_ready = 0; ex_valid = 1; ex_taken = 1; ex_target = 32'h100;
    step();
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      chk_ctl("bp.redir", 1'b1);
      chk("bp.pc", redirect_pc, 32'h100);
      fetch_ready = (k == 4);
      step();
    end
    chk_ctl("bp.done", 1'b0);
    chk_stats("bp", 2, 3);

    // Wrong-path suppression during REDIRECT
    fetch_ready = 0; ex_valid = 1; ex_taken = 1; ex_target = 32'h300;
    step();
    chk("wp.pc0", redirect_pc, 32'h300);
    cmp_valid = 1; cmp_gt = 1; cmp_eq = 0; ex_target = 32'h200;
    step();
    chk("wp.flags", 32'(flags), 32'h2);
    chk("wp.pc", redirect_pc, 32'h300);
    chk_ctl("wp.redir", 1'b1);
    idle_inputs(); fetch_ready = 1;
    step();
    chk_ctl("wp.done", 1'b0);
    step();
    chk_ctl("wp.no2nd", 1'b0);
    chk("wp.flags2", 32'(flags), 32'h2);
    chk_stats("wp", 3, 4);

    // Stall gating of both branch and cmp
    ex_valid = 1; ex_taken = 1; ex_target = 32'h80; stall = 1;
    cmp_valid = 1; cmp_gt = 1; cmp_eq = 0;
    step();
    chk_ctl("stall.1", 1'b0);
    step();
    chk_ctl("stall.2", 1'b0);
    chk("stall.flags", 32'(flags), 32'h2);
    stall = 0; cmp_valid = 0;
    step();
    chk_ctl("stall.rel", 1'b1);
    chk("stall.pc", redirect_pc, 32'h80);

    // Back-to-back: taken branch held through the handshake cycle
    ex_target = 32'hA0;
    step();
    chk_ctl("b2b.gap", 1'b0);
    step();
    chk_ctl("b2b.redir", 1'b1);
    chk("b2b.pc", redirect_pc, 32'hA0);
    idle_inputs();
    step();
    chk_ctl("b2b.done", 1'b0);
    chk_stats("b2b", 5, 4);

    // Wait counter saturation (4-bit counter, 20 stalled cycles)
    fetch_ready = 0; ex_valid = 1; ex_taken = 1; ex_target = 32'hC0;
    step();
    idle_inputs();
    for (int k = 0; k < 20; k++) step();
    chk_ctl("sat.redir", 1'b1);
    chk_stats("sat", 6, 15);
    fetch_ready = 1;
    step();
    chk_ctl("sat.done", 1'b0);

    // Reset mid-redirect, with a concurrent cmp setting flags
    fetch_ready = 0; ex_valid = 1; ex_taken = 1; ex_target = 32'h44;
    cmp_valid = 1; cmp_gt = 1; cmp_eq = 0;
    step();
    chk("rstm.flags", 32'(flags), 32'h1);
    chk_ctl("rstm.redir", 1'b1);
    idle_inputs();
    #2 rst = 1;
    #1;
    chk_ctl("rstm.async", 1'b0);
    chk("rstm.flags0", 32'(flags), 0);
    chk("rstm.pc0", redirect_pc, 0);
    chk_stats("rstm", 0, 0);
    step();
    rst = 0;
    step();
    chk_ctl("rstm.after1", 1'b0);
    step();
    chk_ctl("rstm.after2", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
